// File: rtl/sym_word_aligner.sv
// Comma-based word aligner with LOS/ACQ/SYNC sync FSM.
// Finds the 7-bit singular comma in a 20-bit sliding window, locks the
// 10-bit code-group boundary to it and delivers aligned symbols plus lock.
//
// state | meaning
// LOS   | no alignment; any comma starts acquisition
// ACQ   | candidate offset held; counting consecutive commas at it
// SYNC  | locked; offset frozen; counting commas seen at a wrong offset
module sym_word_aligner #(
    parameter int LOCK_COMMAS = 3,
    parameter int LOSS_COMMAS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] rx_word_in,
    input  logic       rx_valid_in,
    output logic [9:0] sym_out,
    output logic       sym_valid_out,
    output logic       sym_is_comma_out,
    output logic       lock_out,
    output logic [3:0] align_offset_out
);

    typedef enum logic [1:0] {
        ST_LOS  = 2'd0,
        ST_ACQ  = 2'd1,
        ST_SYNC = 2'd2
    } state_t;

    localparam logic [6:0] COMMA_NEG = 7'b1111100;
    localparam logic [6:0] COMMA_POS = 7'b0000011;
    localparam logic [3:0] LOCK_N    = 4'(LOCK_COMMAS);
    localparam logic [3:0] LOSS_N    = 4'(LOSS_COMMAS);

    state_t      state_q, state_d;
    logic [9:0]  prev_q, prev_d;
    logic [3:0]  off_q, off_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  mis_q, mis_d;
    logic [9:0]  sym_q, sym_d;
    logic        sym_valid_q, sym_valid_d;
    logic        sym_comma_q, sym_comma_d;
    logic        lock_q, lock_d;
    logic [3:0]  align_q, align_d;

    logic [19:0] win;
    logic        det_hit;
    logic [3:0]  det_off;
    logic        comma_seen;
    logic        relatch;
    logic [4:0]  sel;
    logic [9:0]  sym;
    logic        sym_is_comma;

    // Comma search over all ten offsets; descending loop so the lowest offset wins.
    always_comb begin
        win     = {rx_word_in, prev_q};
        det_hit = 1'b0;
        det_off = 4'd0;
        for (int p = 9; p >= 0; p--) begin
            if ((win[p +: 7] == COMMA_NEG) || (win[p +: 7] == COMMA_POS)) begin
                det_hit = 1'b1;
                det_off = 4'(p);
            end
        end
    end

    // Sync FSM next state, counters and offset; symbol selection and output staging.
    always_comb begin
        state_d    = state_q;
        off_d      = off_q;
        cnt_d      = cnt_q;
        mis_d      = mis_q;
        relatch    = 1'b0;
        prev_d     = rx_valid_in ? rx_word_in : prev_q;
        comma_seen = rx_valid_in && det_hit;

        if (comma_seen) begin
            case (state_q)
                ST_LOS: begin
                    off_d   = det_off;
                    cnt_d   = 4'd1;
                    relatch = 1'b1;
                    if (LOCK_N == 4'd1) begin
                        state_d = ST_SYNC;
                        mis_d   = 4'd0;
                    end else begin
                        state_d = ST_ACQ;
                    end
                end
                ST_ACQ: begin
                    if (det_off == off_q) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q + 4'd1 == LOCK_N) begin
                            state_d = ST_SYNC;
                            mis_d   = 4'd0;
                        end
                    end else begin
                        off_d   = det_off;
                        cnt_d   = 4'd1;
                        relatch = 1'b1;
                    end
                end
                ST_SYNC: begin
                    if (det_off == off_q) begin
                        mis_d = 4'd0;
                    end else if (mis_q + 4'd1 == LOSS_N) begin
                        // Offset is deliberately kept; the next comma in LOS relatches it.
                        state_d = ST_LOS;
                        cnt_d   = 4'd0;
                        mis_d   = 4'd0;
                    end else begin
                        mis_d = mis_q + 4'd1;
                    end
                end
                default: begin
                    state_d = ST_LOS;
                    cnt_d   = 4'd0;
                    mis_d   = 4'd0;
                end
            endcase
        end

        // A relatching comma is delivered from its own offset, not the stale one.
        sel          = {1'b0, (relatch ? det_off : off_q)};
        sym          = win[sel +: 10];
        sym_is_comma = (sym[6:0] == COMMA_NEG) || (sym[6:0] == COMMA_POS);

        sym_d       = rx_valid_in ? sym : sym_q;
        sym_valid_d = rx_valid_in && (state_d == ST_SYNC);
        sym_comma_d = rx_valid_in && sym_is_comma;
        lock_d      = (state_d == ST_SYNC);
        align_d     = off_d;
    end

    // State, window history and registered outputs; async active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_LOS;
            prev_q      <= 10'd0;
            off_q       <= 4'd0;
            cnt_q       <= 4'd0;
            mis_q       <= 4'd0;
            sym_q       <= 10'd0;
            sym_valid_q <= 1'b0;
            sym_comma_q <= 1'b0;
            lock_q      <= 1'b0;
            align_q     <= 4'd0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            off_q       <= off_d;
            cnt_q       <= cnt_d;
            mis_q       <= mis_d;
            sym_q       <= sym_d;
            sym_valid_q <= sym_valid_d;
            sym_comma_q <= sym_comma_d;
            lock_q      <= lock_d;
            align_q     <= align_d;
        end
    end

    assign sym_out          = sym_q;
    assign sym_valid_out    = sym_valid_q;
    assign sym_is_comma_out = sym_comma_q;
    assign lock_out         = lock_q;
    assign align_offset_out = align_q;

endmodule

// File: tb/tb_sym_word_aligner.sv
// Scoreboard bench for sym_word_aligner: a line bitstream is built from
// symbols and filler bits, sliced into words, and every symbol expected to
// be delivered valid is queued for a free-running monitor.
module tb_sym_word_aligner;

    typedef struct packed {
        logic [9:0] sym;
        logic       comma;
        logic [3:0] off;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [9:0] rx_word_in;
    logic       rx_valid_in;
    logic [9:0] sym_out;
    logic       sym_valid_out;
    logic       sym_is_comma_out;
    logic       lock_out;
    logic [3:0] align_offset_out;

    int   n_checks;
    int   n_fail;
    int   t;
    bit   line[$];
    exp_t exp_q[$];

    sym_word_aligner #(.LOCK_COMMAS(3), .LOSS_COMMAS(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .rx_word_in       (rx_word_in),
        .rx_valid_in      (rx_valid_in),
        .sym_out          (sym_out),
        .sym_valid_out    (sym_valid_out),
        .sym_is_comma_out (sym_is_comma_out),
        .lock_out         (lock_out),
        .align_offset_out (align_offset_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic is_comma_pat(input logic [9:0] s);
        return (s[6:0] == 7'b1111100) || (s[6:0] == 7'b0000011);
    endfunction

    function automatic logic [9:0] get10(input int start);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) r[i] = line[start + i];
        return r;
    endfunction

    task automatic push_sym(input logic [9:0] s);
        for (int i = 0; i < 10; i++) line.push_back(s[i]);
    endtask

    task automatic push_fill(input int n);
        for (int i = 0; i < n; i++) line.push_back((i % 2) == 0);
    endtask

    // Drive word t of the line; if the symbol is expected valid, queue it.
    task automatic send_word(input bit expv, input int off);
        logic [9:0] w;
        exp_t       e;
        w = get10(10 * t);
        @(negedge clk);
        rx_word_in  = w;
        rx_valid_in = 1'b1;
        if (expv) begin
            e.sym   = get10(10 * (t - 1) + off);
            e.comma = is_comma_pat(e.sym);
            e.off   = 4'(off);
            exp_q.push_back(e);
        end
        t++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b1;
        rx_valid_in = 1'b0;
        rx_word_in  = 10'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        line.delete();
        t = 0;
    endtask

    // Monitor: every delivered symbol must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sym_valid_out) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_sym_valid", 32'(sym_valid_out), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_sym", 32'(sym_out), 32'(e.sym));
                    check("sb_comma", 32'(sym_is_comma_out), 32'(e.comma));
                    check("sb_offset", 32'(align_offset_out), 32'(e.off));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        t           = 0;
        rst         = 1'b1;
        rx_valid_in = 1'b0;
        rx_word_in  = 10'd0;
        #12;
        check("rst_sym_out", 32'(sym_out), 32'd0);
        check("rst_sym_valid", 32'(sym_valid_out), 32'd0);
        check("rst_is_comma", 32'(sym_is_comma_out), 32'd0);
        check("rst_lock", 32'(lock_out), 32'd0);
        check("rst_offset", 32'(align_offset_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Lock at offset 3, valid gap, then loss-of-lock sequence.
        push_fill(3);
        push_sym(10'h17C); push_sym(10'h17C); push_sym(10'h17C);
        push_sym(10'h155); push_sym(10'h2AA); push_sym(10'h17C); push_sym(10'h155);
        push_fill(2);
        push_sym(10'h17C); push_sym(10'h155);
        push_fill(8);
        push_sym(10'h17C); push_sym(10'h155);
        push_fill(2);
        push_sym(10'h17C); push_sym(10'h17C);
        push_sym(10'h155); push_sym(10'h2AA); push_sym(10'h155); push_sym(10'h2AA);
        for (int k = 0; k < 17; k++) begin
            send_word(k >= 3 && k <= 13, 3);
            case (k)
                2: check("a_lock_before_3rd", 32'(lock_out), 32'd0);
                3: begin
                    check("a_lock_at_3rd", 32'(lock_out), 32'd1);
                    check("a_offset", 32'(align_offset_out), 32'd3);
                    check("a_first_sym", 32'(sym_out), 32'h17C);
                end
                4: check("a_data_sym", 32'(sym_out), 32'h155);
                5: begin
                    for (int g = 0; g < 4; g++) begin
                        @(negedge clk);
                        rx_valid_in = 1'b0;
                        rx_word_in  = 10'h3FF;
                        @(posedge clk);
                        #1;
                        check("gap_sym_valid", 32'(sym_valid_out), 32'd0);
                        check("gap_sym_hold", 32'(sym_out), 32'h2AA);
                        check("gap_lock", 32'(lock_out), 32'd1);
                    end
                end
                8:  check("d_lock_after_1_mis", 32'(lock_out), 32'd1);
                11: check("d_lock_after_realign", 32'(lock_out), 32'd1);
                13: check("d_lock_after_1_mis_b", 32'(lock_out), 32'd1);
                14: begin
                    check("d_lock_lost", 32'(lock_out), 32'd0);
                    check("d_valid_lost", 32'(sym_valid_out), 32'd0);
                    check("d_offset_kept", 32'(align_offset_out), 32'd3);
                end
                16: check("d_still_los", 32'(lock_out), 32'd0);
                default: ;
            endcase
        end
        @(negedge clk);
        rx_valid_in = 1'b0;
        check("a_queue_drained", 32'(exp_q.size()), 32'd0);

        // Both polarities at offset 0.
        do_reset();
        push_sym(10'h17C); push_sym(10'h283); push_sym(10'h17C);
        push_sym(10'h283); push_sym(10'h17C);
        push_sym(10'h155); push_sym(10'h2AA); push_sym(10'h155); push_sym(10'h2AA);
        for (int k = 0; k < 8; k++) begin
            send_word(k >= 3, 0);
            if (k == 2) check("b_lock_before_3rd", 32'(lock_out), 32'd0);
            if (k == 3) begin
                check("b_lock", 32'(lock_out), 32'd1);
                check("b_offset", 32'(align_offset_out), 32'd0);
            end
            if (k == 4) check("b_rdplus_sym", 32'(sym_out), 32'h283);
            if (k == 5) check("b_rdminus_sym", 32'(sym_out), 32'h17C);
        end
        @(negedge clk);
        rx_valid_in = 1'b0;
        check("b_queue_drained", 32'(exp_q.size()), 32'd0);

        // ACQ restart: commas at offsets 3, 3, 7, 7, 7.
        do_reset();
        push_fill(3);
        push_sym(10'h17C); push_sym(10'h17C);
        push_fill(4);
        push_sym(10'h17C); push_sym(10'h17C); push_sym(10'h17C);
        push_sym(10'h155); push_sym(10'h2AA); push_sym(10'h155); push_sym(10'h2AA);
        for (int k = 0; k < 8; k++) begin
            send_word(k >= 5, 7);
            if (k == 2) check("c_offset_first", 32'(align_offset_out), 32'd3);
            if (k == 3) begin
                check("c_offset_relatch", 32'(align_offset_out), 32'd7);
                check("c_lock_3rd", 32'(lock_out), 32'd0);
            end
            if (k == 4) check("c_lock_4th", 32'(lock_out), 32'd0);
            if (k == 5) begin
                check("c_lock_5th", 32'(lock_out), 32'd1);
                check("c_sym_5th", 32'(sym_out), 32'h17C);
            end
        end

        // Async reset pulse between edges while locked.
        @(negedge clk);
        rx_valid_in = 1'b0;
        check("e_locked_before_rst", 32'(lock_out), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("e_rst_lock", 32'(lock_out), 32'd0);
        check("e_rst_valid", 32'(sym_valid_out), 32'd0);
        check("e_rst_offset", 32'(align_offset_out), 32'd0);
        check("e_rst_sym", 32'(sym_out), 32'd0);
        #1;
        rst = 1'b0;
        line.delete();
        t = 0;
        check("c_queue_drained", 32'(exp_q.size()), 32'd0);
        push_sym(10'h17C); push_sym(10'h17C); push_sym(10'h17C);
        push_sym(10'h155); push_sym(10'h2AA); push_sym(10'h155);
        for (int k = 0; k < 5; k++) begin
            send_word(k >= 3, 0);
            if (k == 1) check("e_relock_1", 32'(lock_out), 32'd0);
            if (k == 2) check("e_relock_2", 32'(lock_out), 32'd0);
            if (k == 3) check("e_relock_3", 32'(lock_out), 32'd1);
        end
        @(negedge clk);
        rx_valid_in = 1'b0;
        @(negedge clk);
        check("e_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
